// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store controller between the CPU MEM stage and a word-addressed,
//   two-cycle BRAM (data_memory). It takes one byte/half/word request at a
//   time, drives the memory port from latched request state, and returns
//   sign/zero-extended load data. Sub-word stores are read-modify-write.
//
//   Optional feature macro: LSU_MISALIGN_CHK_EN
//     defined   : misaligned half/word requests skip memory and complete
//                 with resp_err=1 one cycle after acceptance.
//     undefined : resp_err is tied 0 and misaligned requests are forced to
//                 natural alignment (half uses addr[1], word ignores [1:0]).
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid/we/size/signed/addr/wdata   request from MEM stage
//     busy                  request in flight, upstream must stall
//     resp_valid/rdata/err  one-cycle completion pulse and load data
//     mem_address/data_in/write/read        data_memory command port
//     mem_data_out, mem_stall               data_memory read data, stall
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             busy,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_err,
   output logic [WIDTH-1:0] mem_address,
   output logic [31:0]      mem_data_in,
   output logic             mem_write,
   output logic             mem_read,
   input  logic [31:0]      mem_data_out,
   input  logic             mem_stall
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_reg;
   logic        req_we_reg;
   logic [1:0]  req_size_reg;
   logic        req_signed_reg;
   logic [1:0]  addr_lo_reg;
   logic [31:0] req_wdata_reg;
   logic [31:0] rdata_q_reg;
   logic        busy_reg;
   logic        resp_valid_reg;
   logic        resp_err_reg;
   logic        mem_read_reg;
   logic        mem_write_reg;
   logic [WIDTH-1:0] mem_address_reg;
   logic [31:0] mem_data_in_reg;

   // Address bits above the word-address window are deliberately dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:WIDTH+2];

   // Insert the store lane(s) into the word just read from memory.
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic [31:0] wdata);
      logic [31:0] m;
      m = word;
      if (size == 2'b00) begin
         case (lo)
            2'd0:    m[7:0]   = wdata[7:0];
            2'd1:    m[15:8]  = wdata[7:0];
            2'd2:    m[23:16] = wdata[7:0];
            default: m[31:24] = wdata[7:0];
         endcase
      end else if (size == 2'b01) begin
         if (lo[1]) m[31:16] = wdata[15:0];
         else       m[15:0]  = wdata[15:0];
      end else begin
         m = wdata;
      end
      return m;
   endfunction

   // Shift the addressed lane down to bit 0 and extend it.
   function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        sgn,
                                                input logic [1:0]  lo);
      logic [31:0] sh;
      logic [31:0] r;
      r = word;
      if (size == 2'b00) begin
         sh = word >> {lo, 3'b000};
         r  = {{24{sgn & sh[7]}}, sh[7:0]};
      end else if (size == 2'b01) begin
         sh = word >> {lo[1], 4'b0000};
         r  = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      return r;
   endfunction

   logic misalign;
`ifdef LSU_MISALIGN_CHK_EN
   always_comb begin
      misalign = 1'b0;
      if (req_size == 2'b01)
         misalign = req_addr[0];
      else if (req_size[1])
         misalign = (req_addr[1:0] != 2'b00);
   end
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         req_we_reg      <= 1'b0;
         req_size_reg    <= 2'b00;
         req_signed_reg  <= 1'b0;
         addr_lo_reg     <= 2'b00;
         req_wdata_reg   <= '0;
         rdata_q_reg     <= '0;
         busy_reg        <= 1'b0;
         resp_valid_reg  <= 1'b0;
         resp_err_reg    <= 1'b0;
         mem_read_reg    <= 1'b0;
         mem_write_reg   <= 1'b0;
         mem_address_reg <= '0;
         mem_data_in_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  req_we_reg      <= req_we;
                  req_size_reg    <= req_size;
                  req_signed_reg  <= req_signed;
                  addr_lo_reg     <= req_addr[1:0];
                  req_wdata_reg   <= req_wdata;
                  rdata_q_reg     <= '0;
                  mem_address_reg <= req_addr[WIDTH+1:2];
                  busy_reg        <= 1'b1;
                  if (misalign) begin
                     state_reg      <= RESP;
                     resp_valid_reg <= 1'b1;
                     resp_err_reg   <= 1'b1;
                  end else if (req_we && req_size[1]) begin
                     state_reg       <= WR;
                     mem_write_reg   <= 1'b1;
                     mem_data_in_reg <= req_wdata;
                  end else begin
                     state_reg    <= RD;
                     mem_read_reg <= 1'b1;
                  end
               end
            end
            RD: begin
               if (!mem_stall) begin
                  rdata_q_reg  <= mem_data_out;
                  mem_read_reg <= 1'b0;
                  if (req_we_reg) begin
                     state_reg       <= WR;
                     mem_write_reg   <= 1'b1;
                     mem_data_in_reg <= merge_lane(mem_data_out, req_size_reg,
                                                   addr_lo_reg, req_wdata_reg);
                  end else begin
                     state_reg      <= RESP;
                     resp_valid_reg <= 1'b1;
                  end
               end
            end
            WR: begin
               if (!mem_stall) begin
                  mem_write_reg  <= 1'b0;
                  state_reg      <= RESP;
                  resp_valid_reg <= 1'b1;
               end
            end
            default: begin
               state_reg      <= IDLE;
               busy_reg       <= 1'b0;
               resp_valid_reg <= 1'b0;
               resp_err_reg   <= 1'b0;
            end
         endcase
      end
   end

   // Load data is only presented with the response; stores and errored
   // requests return zero.
   always_comb begin
      resp_rdata = '0;
      if (resp_valid_reg && !req_we_reg && !resp_err_reg)
         resp_rdata = extract_lane(rdata_q_reg, req_size_reg, req_signed_reg,
                                   addr_lo_reg);
   end

   assign busy        = busy_reg;
   assign resp_valid  = resp_valid_reg;
   assign resp_err    = resp_err_reg;
   assign mem_read    = mem_read_reg;
   assign mem_write   = mem_write_reg;
   assign mem_address = mem_address_reg;
   assign mem_data_in = mem_data_in_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        busy, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [15:0] mem_address;
   logic [31:0] mem_data_in, mem_data_out;
   logic        mem_write, mem_read, mem_stall;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          rd;
      int          wr;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_read(mem_read),
      .mem_data_out(mem_data_out), .mem_stall(mem_stall)
   );

   // data_memory model: stall high in the first cycle of each access.
   logic [31:0] tbmem [16];
   logic        in_prog;
   assign mem_stall    = (mem_read | mem_write) & ~in_prog;
   assign mem_data_out = tbmem[mem_address[3:0]];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_prog <= 1'b0;
      else if (mem_read | mem_write) begin
         in_prog <= ~in_prog;
         if (mem_write && !mem_stall) tbmem[mem_address[3:0]] <= mem_data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request (called at a negedge), follow it to its response.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hold,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input int rd, input int wr);
      int cyc, rc, wc;
      logic got;
      exp_t e;
      sb.push_back('{exp_rdata, exp_err, lat, rd, wr});
      req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      cyc = 0; rc = 0; wc = 0; got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (mem_read)  rc++;
         if (mem_write) wc++;
         if (mem_read | mem_write)
            chk({tag, "_addr"}, 32'(mem_address), 32'(addr[17:2]));
         if (resp_valid) begin
            got = 1'b1;
            req_valid = 1'b0;
         end else begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (hold) req_addr = $urandom;
         end
      end
      if (!got) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         $display("txn %s: rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
                  tag, resp_rdata, resp_err, cyc, rc, wc);
         chk({tag, "_rdata"}, resp_rdata, e.rdata);
         chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
         chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
         chk({tag, "_rdcyc"}, 32'(rc), 32'(e.rd));
         chk({tag, "_wrcyc"}, 32'(wc), 32'(e.wr));
      end
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp", 32'(resp_valid), 32'd0);
      chk("rst_rd", 32'(mem_read), 32'd0);
      chk("rst_wr", 32'(mem_write), 32'd0);
      chk("rst_addr", 32'(mem_address), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_din", mem_data_in, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_req("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 3, 0, 2);
      chk("mem_w", tbmem[4], 32'hDEADBEEF);
      do_req("ld_w", 0, 2'b10, 1, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 3, 2, 0);
      do_req("st_w2", 1, 2'b11, 0, 32'h10, 32'h80FF7F01, 0, 32'h0, 0, 3, 0, 2);
      do_req("ld_b11s", 0, 2'b00, 1, 32'h11, 32'h0, 0, 32'h0000007F, 0, 3, 2, 0);
      do_req("ld_b13s", 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFF80, 0, 3, 2, 0);
      do_req("ld_b13u", 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h00000080, 0, 3, 2, 0);
      do_req("st_b12", 1, 2'b00, 0, 32'h12, 32'h555555AA, 0, 32'h0, 0, 5, 2, 2);
      chk("mem_b", tbmem[4], 32'h80AA7F01);
      do_req("st_h10", 1, 2'b01, 0, 32'h10, 32'hFFFF1234, 0, 32'h0, 0, 5, 2, 2);
      chk("mem_h", tbmem[4], 32'h80AA1234);
      do_req("ld_h12s", 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFF80AA, 0, 3, 2, 0);
      do_req("ld_h10u", 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h00001234, 0, 3, 2, 0);
      do_req("ld_hiaddr", 0, 2'b10, 0, 32'hFFFC0010, 32'h0, 0, 32'h80AA1234, 0, 3, 2, 0);
      do_req("hold", 0, 2'b00, 0, 32'h10, 32'h0, 1, 32'h00000034, 0, 3, 2, 0);
`ifdef LSU_MISALIGN_CHK_EN
      do_req("ld_mis", 0, 2'b10, 0, 32'h11, 32'h0, 0, 32'h0, 1, 1, 0, 0);
      do_req("st_mis", 1, 2'b01, 0, 32'h13, 32'h0000BEEF, 0, 32'h0, 1, 1, 0, 0);
      chk("mem_mis", tbmem[4], 32'h80AA1234);
`else
      do_req("ld_mis", 0, 2'b10, 0, 32'h11, 32'h0, 0, 32'h80AA1234, 0, 3, 2, 0);
      do_req("ld_h11", 0, 2'b01, 0, 32'h11, 32'h0, 0, 32'h00001234, 0, 3, 2, 0);
`endif

      // Reset in the middle of a read aborts without a response.
      req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_rd", 32'(mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd", 32'(mem_read), 32'd0);
      chk("abort_addr", 32'(mem_address), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_noresp", 32'(resp_valid | busy), 32'd0);
      end
      $display("txn reset_abort: busy=%0d resp_valid=%0d", busy, resp_valid);

      do_req("post_rst", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80AA1234, 0, 3, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
